seg_disp_sched: RTL

Arbiter and scan scheduler for the shared 5-digit seven-segment display. It shares the display between three requesters (0 = alarm/status, 1 = wave A frequency, 2 = wave B frequency) on frame boundaries, with minimum hold time and priority preemption. It also generates the multiplexed digit-select timing with an inter-digit blanking gap. It outputs the BCD code and the active-low digit select to the downstream segment decoder.

---
 rtl/seg_disp_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg_disp_sched.sv
// Display arbiter and digit scan generator for the shared 5-digit seven-segment display.
// Ownership changes only on frame boundaries; scan outputs are registered one cycle after scan state.
//
// state  | meaning
// ACTIVE | current digit slot is driven from the shadow register
// BLANK  | tail of the slot, all digits off to prevent ghosting
module seg_disp_sched #(
  parameter int SCAN_DIV    = 50_000,
  parameter int BLANK_CYC   = 500,
  parameter int HOLD_FRAMES = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [4:0]  dig_sel,
  output logic [3:0]  dig_code,
  output logic        frame_tick
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  ACT_END  = CNT_W'(SCAN_DIV - BLANK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  typedef enum logic {ACTIVE, BLANK} scan_t;

  scan_t             state;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [1:0]        last_owner;
  logic [1:0]        last_nxt;
  logic [1:0]        owner;
  logic [1:0]        cand;
  logic [1:0]        p1;
  logic [1:0]        p2;
  logic [1:0]        p3;
  logic              owner_vld;
  logic              cand_vld;
  logic              other_vld;
  logic [2:0]        grant_nxt;
  logic [19:0]       shadow;
  logic [19:0]       shadow_nxt;
  logic [19:0]       shadow_cur;

  function automatic logic [1:0] next_rr(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign frame_tick = (state == ACTIVE) && (idx == 3'd0) && (cnt == '0);
  assign busy       = |grant;
  assign owner_vld  = |grant;
  assign owner      = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
  assign p1         = next_rr(last_owner);
  assign p2         = next_rr(p1);
  assign p3         = next_rr(p2);
  assign cnt_nxt    = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

  // Alarm requester always wins; otherwise round-robin after the last owner, skipping the current one.
  always_comb begin
    cand_vld = 1'b0;
    cand     = 2'd0;
    if (req[0]) begin
      cand_vld = 1'b1;
      cand     = 2'd0;
    end else if (req[p1] && !(owner_vld && p1 == owner)) begin
      cand_vld = 1'b1;
      cand     = p1;
    end else if (req[p2] && !(owner_vld && p2 == owner)) begin
      cand_vld = 1'b1;
      cand     = p2;
    end else if (req[p3] && !(owner_vld && p3 == owner)) begin
      cand_vld = 1'b1;
      cand     = p3;
    end
  end

  assign other_vld = cand_vld && !(owner_vld && cand == owner);

  always_comb begin
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    last_nxt  = last_owner;
    if (!owner_vld) begin
      if (cand_vld) begin
        grant_nxt = 3'b001 << cand;
        hold_nxt  = HOLD_W'(1);
        last_nxt  = cand;
      end
    end else if (!req[owner]) begin
      if (cand_vld) begin
        grant_nxt = 3'b001 << cand;
        hold_nxt  = HOLD_W'(1);
        last_nxt  = cand;
      end else begin
        grant_nxt = 3'b000;
        hold_nxt  = '0;
      end
    end else if (owner != 2'd0 && req[0]) begin
      grant_nxt = 3'b001;
      hold_nxt  = HOLD_W'(1);
      last_nxt  = 2'd0;
    end else if (hold_cnt >= HOLD_MAX && other_vld) begin
      grant_nxt = 3'b001 << cand;
      hold_nxt  = HOLD_W'(1);
      last_nxt  = cand;
    end else if (hold_cnt < HOLD_MAX) begin
      hold_nxt  = hold_cnt + HOLD_W'(1);
    end
  end

  always_comb begin
    case (grant_nxt)
      3'b001:  shadow_nxt = data0;
      3'b010:  shadow_nxt = data1;
      3'b100:  shadow_nxt = data2;
      default: shadow_nxt = 20'hFFFFF;
    endcase
  end

  // On the tick cycle digit 0 must already show the newly latched frame data.
  assign shadow_cur = frame_tick ? shadow_nxt : shadow;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ACTIVE;
      idx        <= 3'd0;
      cnt        <= '0;
      grant      <= 3'b000;
      hold_cnt   <= '0;
      last_owner <= 2'd0;
      shadow     <= 20'hFFFFF;
      dig_sel    <= 5'b11111;
      dig_code   <= 4'hF;
    end else begin
      cnt   <= cnt_nxt;
      state <= (cnt_nxt < ACT_END) ? ACTIVE : BLANK;
      if (cnt == CNT_LAST) begin
        idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end
      if (frame_tick) begin
        grant      <= grant_nxt;
        hold_cnt   <= hold_nxt;
        last_owner <= last_nxt;
        shadow     <= shadow_nxt;
      end
      if (state == ACTIVE) begin
        dig_sel  <= ~(5'b00001 << idx);
        dig_code <= shadow_cur[{idx, 2'b00} +: 4];
      end else begin
        dig_sel  <= 5'b11111;
        dig_code <= 4'hF;
      end
    end
  end

endmodule
